apbreg_ir_mc: RTL and testbench

Parametrised APB register slave for a multi-channel NEC-style IR receiver, sitting between the APB bus and CH instances of the IR decoder core. It provides per-channel timing/threshold configuration, sticky W1C interrupt status with a mask and a single `irq` output, and a shared receive FIFO. The FIFO queues decoded frames from all channels tagged with channel id, so software no longer loses frames between polls.

---
 rtl/ir_pkg.sv | 45 ++++
 rtl/ir_rx_fifo.sv | 47 ++++
 rtl/apbreg_ir_mc.sv | 249 ++++++++++++++++++++++++
 tb/tb_apbreg_ir_mc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared constants and types for the multi-channel IR receiver register slave.
package ir_pkg;

  localparam logic [23:0] ADDR_INT_STAT  = 24'h000;
  localparam logic [23:0] ADDR_INT_MASK  = 24'h004;
  localparam logic [23:0] ADDR_FIFO_STAT = 24'h008;
  localparam logic [23:0] ADDR_RX_DATA   = 24'h00C;
  localparam logic [23:0] ADDR_RX_TAG    = 24'h010;

  localparam logic [23:0] CH_BASE   = 24'h100;
  localparam int          CH_STRIDE = 32'h20;

  localparam logic [4:0] OFS_CTRL  = 5'h00;
  localparam logic [4:0] OFS_NOISE = 5'h04;
  localparam logic [4:0] OFS_EDGE  = 5'h08;
  localparam logic [4:0] OFS_9MS   = 5'h0C;
  localparam logic [4:0] OFS_4P5   = 5'h10;
  localparam logic [4:0] OFS_1P69  = 5'h14;
  localparam logic [4:0] OFS_2P25  = 5'h18;

  localparam int RXDONE_LSB = 0;
  localparam int CMPERR_LSB = 8;
  localparam int OVF_BIT    = 16;

  localparam logic [7:0]  NOISE_RST   = 8'h05;
  localparam logic [12:0] EDGE_RST    = 13'h1F4;
  localparam logic [17:0] CNT_9MS_RST = 18'h222E0;
  localparam logic [17:0] CNT_4P5_RST = 18'h11170;
  localparam logic [17:0] CNT_1P69_RST = 18'h03A98;
  localparam logic [17:0] CNT_2P25_RST = 18'h084D0;

  localparam int ENTRY_W = 36;

  typedef struct packed {
    logic        rep;
    logic [2:0]  ch;
    logic [31:0] data;
  } rx_entry_t;

  // Base byte address of channel c's register block.
  function automatic logic [23:0] chan_addr(input int c);
    return CH_BASE + 24'(c * CH_STRIDE);
  endfunction

endpackage

// File: rtl/ir_rx_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module ir_rx_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic                     pclk,
  input  logic                     prst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge pclk) begin
    if (prst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/apbreg_ir_mc.sv
// APB register slave for CH IR decoder channels: per-channel config, sticky W1C status,
// masked irq and a shared receive FIFO of channel-tagged frames.
module apbreg_ir_mc
  import ir_pkg::*;
#(
  parameter int CH         = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [23:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [CH-1:0]     ir_int,
  input  logic [CH-1:0]     ir_cmp_err,
  input  logic [CH-1:0]     ir_repeat,
  input  logic [32*CH-1:0]  ir_data,
  output logic              irq,
  output logic [CH-1:0]     rf_data_cmp_en,
  output logic [CH-1:0]     rf_addr_cmp_en,
  output logic [CH-1:0]     rf_ir_phase,
  output logic [CH-1:0]     rf_cmp_clr,
  output logic [CH-1:0]     rf_int_clr,
  output logic [8*CH-1:0]   rf_niose_th,
  output logic [13*CH-1:0]  rf_edge_th,
  output logic [18*CH-1:0]  rf_9ms_cnt,
  output logic [18*CH-1:0]  rf_4p5_cnt,
  output logic [18*CH-1:0]  rf_1p69_cnt,
  output logic [18*CH-1:0]  rf_2p25_cnt
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [23:0]      addr;
  logic [4:0]       ch_off;
  logic [CH-1:0]    chan_hit;
  logic             wr_en, rd_setup, rd_access, mapped;
  logic             stat_wr, mask_wr;
  logic [31:0]      rd_val;
  logic [CH-1:0]    rx_done, cmp_err, mask_rx, mask_cmp;
  logic             fifo_ovf, mask_ovf, ovf_set;
  logic [CH-1:0]    w1c_rx, w1c_cmp;
  logic [31:0]      int_stat_vec, int_mask_vec, fifo_stat_vec, rx_tag_vec;
  logic [CH-1:0]    pending, push_sel, hold_rep;
  logic [31:0]      hold_data [CH];
  rx_entry_t        push_entry, head;
  logic             push, pop, fifo_full, fifo_empty, found;
  logic [LVL_W-1:0] fifo_level;
  logic             tag_rep;
  logic [2:0]       tag_ch;
  logic             unused_bits;

  assign addr        = paddr & 24'hFFFFFC;
  assign ch_off      = addr[4:0];
  assign unused_bits = ^pwdata[31:18];

  assign wr_en     = psel & penable & pwrite;
  assign rd_setup  = psel & ~penable & ~pwrite;
  assign rd_access = psel & penable & ~pwrite;
  assign stat_wr   = wr_en && (addr == ADDR_INT_STAT);
  assign mask_wr   = wr_en && (addr == ADDR_INT_MASK);
  assign pop       = rd_access && (addr == ADDR_RX_DATA);

  assign pready  = 1'b1;
  assign pslverr = psel & penable & ~mapped;

  always_comb begin
    chan_hit = '0;
    for (int c = 0; c < CH; c++)
      chan_hit[c] = ((addr & 24'hFFFFE0) == chan_addr(c)) && (ch_off <= OFS_2P25);
  end

  always_comb begin
    int_stat_vec = '0;
    int_stat_vec[RXDONE_LSB +: CH] = rx_done;
    int_stat_vec[CMPERR_LSB +: CH] = cmp_err;
    int_stat_vec[OVF_BIT]          = fifo_ovf;
    int_mask_vec = '0;
    int_mask_vec[RXDONE_LSB +: CH] = mask_rx;
    int_mask_vec[CMPERR_LSB +: CH] = mask_cmp;
    int_mask_vec[OVF_BIT]          = mask_ovf;
    fifo_stat_vec = '0;
    fifo_stat_vec[LVL_W-1:0] = fifo_level;
    fifo_stat_vec[8]         = fifo_empty;
    fifo_stat_vec[9]         = fifo_full;
    rx_tag_vec = '0;
    rx_tag_vec[2:0] = tag_ch;
    rx_tag_vec[8]   = tag_rep;
  end

  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (addr)
      ADDR_INT_STAT:  rd_val = int_stat_vec;
      ADDR_INT_MASK:  rd_val = int_mask_vec;
      ADDR_FIFO_STAT: rd_val = fifo_stat_vec;
      ADDR_RX_DATA:   rd_val = fifo_empty ? 32'h0 : head.data;
      ADDR_RX_TAG:    rd_val = rx_tag_vec;
      default:        mapped = |chan_hit;
    endcase
    for (int c = 0; c < CH; c++) begin
      if (chan_hit[c]) begin
        case (ch_off)
          OFS_CTRL:  rd_val = {29'b0, rf_data_cmp_en[c], rf_addr_cmp_en[c], rf_ir_phase[c]};
          OFS_NOISE: rd_val = {24'b0, rf_niose_th[8*c +: 8]};
          OFS_EDGE:  rd_val = {19'b0, rf_edge_th[13*c +: 13]};
          OFS_9MS:   rd_val = {14'b0, rf_9ms_cnt[18*c +: 18]};
          OFS_4P5:   rd_val = {14'b0, rf_4p5_cnt[18*c +: 18]};
          OFS_1P69:  rd_val = {14'b0, rf_1p69_cnt[18*c +: 18]};
          OFS_2P25:  rd_val = {14'b0, rf_2p25_cnt[18*c +: 18]};
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (prst)          prdata <= '0;
    else if (rd_setup) prdata <= rd_val;
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      rf_ir_phase    <= '1;
      rf_addr_cmp_en <= '0;
      rf_data_cmp_en <= '0;
      rf_niose_th    <= {CH{NOISE_RST}};
      rf_edge_th     <= {CH{EDGE_RST}};
      rf_9ms_cnt     <= {CH{CNT_9MS_RST}};
      rf_4p5_cnt     <= {CH{CNT_4P5_RST}};
      rf_1p69_cnt    <= {CH{CNT_1P69_RST}};
      rf_2p25_cnt    <= {CH{CNT_2P25_RST}};
    end else if (wr_en) begin
      for (int c = 0; c < CH; c++) begin
        if (chan_hit[c]) begin
          case (ch_off)
            OFS_CTRL: begin
              rf_ir_phase[c]    <= pwdata[0];
              rf_addr_cmp_en[c] <= pwdata[1];
              rf_data_cmp_en[c] <= pwdata[2];
            end
            OFS_NOISE: rf_niose_th[8*c +: 8]  <= pwdata[7:0];
            OFS_EDGE:  rf_edge_th[13*c +: 13] <= pwdata[12:0];
            OFS_9MS:   rf_9ms_cnt[18*c +: 18]  <= pwdata[17:0];
            OFS_4P5:   rf_4p5_cnt[18*c +: 18]  <= pwdata[17:0];
            OFS_1P69:  rf_1p69_cnt[18*c +: 18] <= pwdata[17:0];
            OFS_2P25:  rf_2p25_cnt[18*c +: 18] <= pwdata[17:0];
            default:   ;
          endcase
        end
      end
    end
  end

  assign w1c_rx  = stat_wr ? pwdata[RXDONE_LSB +: CH] : '0;
  assign w1c_cmp = stat_wr ? pwdata[CMPERR_LSB +: CH] : '0;
  assign ovf_set = push & fifo_full & ~(pop & ~fifo_empty);

  // Hardware sets are OR-ed in after the W1C mask so a coincident set wins over the clear.
  always_ff @(posedge pclk) begin
    if (prst) begin
      rx_done    <= '0;
      cmp_err    <= '0;
      fifo_ovf   <= 1'b0;
      rf_int_clr <= '0;
      rf_cmp_clr <= '0;
      mask_rx    <= '0;
      mask_cmp   <= '0;
      mask_ovf   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      rx_done    <= (rx_done & ~w1c_rx) | ir_int;
      cmp_err    <= (cmp_err & ~w1c_cmp) | ir_cmp_err;
      fifo_ovf   <= (fifo_ovf & ~(stat_wr & pwdata[OVF_BIT])) | ovf_set;
      rf_int_clr <= w1c_rx;
      rf_cmp_clr <= w1c_cmp;
      if (mask_wr) begin
        mask_rx  <= pwdata[RXDONE_LSB +: CH];
        mask_cmp <= pwdata[CMPERR_LSB +: CH];
        mask_ovf <= pwdata[OVF_BIT];
      end
      irq <= |(int_stat_vec & int_mask_vec);
    end
  end

  always_comb begin
    push_sel   = '0;
    push_entry = '0;
    found      = 1'b0;
    for (int c = 0; c < CH; c++) begin
      if (pending[c] && !found) begin
        found           = 1'b1;
        push_sel[c]     = 1'b1;
        push_entry.rep  = hold_rep[c];
        push_entry.ch   = 3'(c);
        push_entry.data = hold_data[c];
      end
    end
  end

  assign push = |pending;

  // A new frame on the channel being pushed keeps it pending with the newer data.
  always_ff @(posedge pclk) begin
    if (prst) pending <= '0;
    else      pending <= ir_int | (pending & ~push_sel);
  end

  always_ff @(posedge pclk) begin
    for (int c = 0; c < CH; c++) begin
      if (ir_int[c]) begin
        hold_data[c] <= ir_data[32*c +: 32];
        hold_rep[c]  <= ir_repeat[c];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      tag_rep <= 1'b0;
      tag_ch  <= '0;
    end else if (pop && !fifo_empty) begin
      tag_rep <= head.rep;
      tag_ch  <= head.ch;
    end
  end

  ir_rx_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .pclk  (pclk),
    .prst  (prst),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_apbreg_ir_mc.sv
// Directed bench for apbreg_ir_mc: register map, config writes, FIFO ordering/overflow, irq and W1C.
module tb_apbreg_ir_mc;

  localparam int CH         = 2;
  localparam int FIFO_DEPTH = 8;

  logic              pclk = 1'b0;
  logic              prst;
  logic              psel, penable, pwrite;
  logic [23:0]       paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready, pslverr;
  logic [CH-1:0]     ir_int, ir_cmp_err, ir_repeat;
  logic [32*CH-1:0]  ir_data;
  logic              irq;
  logic [CH-1:0]     rf_data_cmp_en, rf_addr_cmp_en, rf_ir_phase, rf_cmp_clr, rf_int_clr;
  logic [8*CH-1:0]   rf_niose_th;
  logic [13*CH-1:0]  rf_edge_th;
  logic [18*CH-1:0]  rf_9ms_cnt, rf_4p5_cnt, rf_1p69_cnt, rf_2p25_cnt;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  apbreg_ir_mc #(.CH(CH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .pclk(pclk), .prst(prst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .ir_int(ir_int), .ir_cmp_err(ir_cmp_err), .ir_repeat(ir_repeat), .ir_data(ir_data),
    .irq(irq), .rf_data_cmp_en(rf_data_cmp_en), .rf_addr_cmp_en(rf_addr_cmp_en),
    .rf_ir_phase(rf_ir_phase), .rf_cmp_clr(rf_cmp_clr), .rf_int_clr(rf_int_clr),
    .rf_niose_th(rf_niose_th), .rf_edge_th(rf_edge_th), .rf_9ms_cnt(rf_9ms_cnt),
    .rf_4p5_cnt(rf_4p5_cnt), .rf_1p69_cnt(rf_1p69_cnt), .rf_2p25_cnt(rf_2p25_cnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [CH-1:0] ints, input logic [CH-1:0] cmps,
                               input logic [CH-1:0] reps, input logic [32*CH-1:0] data);
    @(posedge pclk); #1;
    ir_int = ints; ir_cmp_err = cmps; ir_repeat = reps; ir_data = data;
    @(posedge pclk); #1;
    ir_int = '0; ir_cmp_err = '0; ir_repeat = '0;
  endtask

  task automatic apb_write(input logic [23:0] a, input logic [31:0] d, output logic err);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [23:0] a, output logic [31:0] d, output logic err);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1 err = pslverr; d = prdata;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [23:0] a, input logic [31:0] expected);
    logic [31:0] d;
    logic        e;
    apb_read(a, d, e);
    checkOutput(tag, {32'h0, d}, {32'h0, expected});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;

    prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    ir_int = '0; ir_cmp_err = '0; ir_repeat = '0; ir_data = '0;
    repeat (3) @(posedge pclk);
    #1 prst = 1'b0;

    // Reset values on the outputs and through the register map.
    checkOutput("rst_phase", 64'(rf_ir_phase), 64'h3);
    checkOutput("rst_acmp", 64'(rf_addr_cmp_en), 64'h0);
    checkOutput("rst_dcmp", 64'(rf_data_cmp_en), 64'h0);
    checkOutput("rst_noise", 64'(rf_niose_th), 64'h0505);
    checkOutput("rst_edge", 64'(rf_edge_th), 64'({2{13'h1F4}}));
    checkOutput("rst_9ms", 64'(rf_9ms_cnt), 64'({2{18'h222E0}}));
    checkOutput("rst_2p25", 64'(rf_2p25_cnt), 64'({2{18'h084D0}}));
    checkOutput("rst_prdata", 64'(prdata), 64'h0);
    checkOutput("rst_irq", 64'(irq), 64'h0);
    checkOutput("rst_pready", 64'(pready), 64'h1);
    check_read("rd_int_stat", 24'h000, 32'h0);
    check_read("rd_int_mask", 24'h004, 32'h0);
    check_read("rd_fifo_stat", 24'h008, 32'h100);
    check_read("rd_rx_data", 24'h00C, 32'h0);
    check_read("rd_rx_tag", 24'h010, 32'h0);
    check_read("rd_ch0_ctrl", 24'h100, 32'h1);
    check_read("rd_ch0_noise", 24'h104, 32'h5);
    check_read("rd_ch0_edge", 24'h108, 32'h1F4);
    check_read("rd_ch0_9ms", 24'h10C, 32'h222E0);
    check_read("rd_ch0_4p5", 24'h110, 32'h11170);
    check_read("rd_ch0_1p69", 24'h114, 32'h3A98);
    check_read("rd_ch1_2p25", 24'h138, 32'h84D0);
    apb_read(24'h300, d, e);
    checkOutput("unmapped_data", 64'(d), 64'h0);
    checkOutput("unmapped_err", 64'(e), 64'h1);
    apb_read(24'h11C, d, e);
    checkOutput("hole_err", 64'(e), 64'h1);
    apb_read(24'h104, d, e);
    checkOutput("mapped_err", 64'(e), 64'h0);

    // Channel 1 config writes.
    apb_write(24'h120, 32'h7, e);
    checkOutput("wr_ctrl_err", 64'(e), 64'h0);
    checkOutput("ch1_phase", 64'(rf_ir_phase), 64'h3);
    checkOutput("ch1_acmp", 64'(rf_addr_cmp_en), 64'h2);
    checkOutput("ch1_dcmp", 64'(rf_data_cmp_en), 64'h2);
    apb_write(24'h12C, 32'h1ABCD, e);
    checkOutput("ch1_9ms", 64'(rf_9ms_cnt), 64'({18'h1ABCD, 18'h222E0}));
    check_read("rb_ch1_ctrl", 24'h120, 32'h7);
    check_read("rb_ch1_9ms", 24'h12C, 32'h1ABCD);
    check_read("rb_ch0_ctrl", 24'h100, 32'h1);
    apb_write(24'h300, 32'hFFFF_FFFF, e);
    checkOutput("wr_unmapped_err", 64'(e), 64'h1);
    apb_write(24'h008, 32'h0000_0205, e);
    check_read("ro_ignored", 24'h008, 32'h100);

    // Two channels in the same cycle: lower channel is queued first.
    applyStimulus(2'b11, 2'b00, 2'b10, {32'hB2, 32'hA1});
    repeat (3) @(posedge pclk);
    #1;
    check_read("two_level", 24'h008, 32'h002);
    check_read("pop1_data", 24'h00C, 32'hA1);
    check_read("pop1_tag", 24'h010, 32'h000);
    check_read("pop2_data", 24'h00C, 32'hB2);
    check_read("pop2_tag", 24'h010, 32'h101);
    check_read("pop3_empty", 24'h00C, 32'h0);
    check_read("pop3_level", 24'h008, 32'h100);
    check_read("pop3_tag", 24'h010, 32'h101);

    // Compare error on channel 1, then W1C it.
    applyStimulus(2'b00, 2'b10, 2'b00, '0);
    check_read("cmp_stat", 24'h000, 32'h203);
    apb_write(24'h000, 32'h200, e);
    checkOutput("cmp_clr_pulse", 64'(rf_cmp_clr), 64'h2);
    @(posedge pclk); #1;
    checkOutput("cmp_clr_end", 64'(rf_cmp_clr), 64'h0);
    check_read("cmp_cleared", 24'h000, 32'h003);
    apb_write(24'h000, 32'hFFFF_FFFF, e);
    check_read("all_cleared", 24'h000, 32'h0);

    // Nine frames into an eight-deep FIFO.
    for (int i = 0; i < 9; i++) begin
      d = 32'h100 + 32'(i);
      applyStimulus(2'b01, 2'b00, 2'b00, {32'h0, d});
    end
    repeat (2) @(posedge pclk);
    #1;
    check_read("ovf_fifo_stat", 24'h008, 32'h208);
    check_read("ovf_int_stat", 24'h000, 32'h10001);
    for (int i = 0; i < 8; i++) begin
      apb_read(24'h00C, d, e);
      checkOutput($sformatf("ovf_pop%0d", i), 64'(d), 64'(32'h100 + 32'(i)));
    end
    check_read("ovf_drained", 24'h008, 32'h100);
    apb_write(24'h000, 32'hFFFF_FFFF, e);

    // Masked irq path and W1C pulse toward the decoder.
    apb_write(24'h004, 32'h1, e);
    check_read("mask_rb", 24'h004, 32'h1);
    checkOutput("irq_idle", 64'(irq), 64'h0);
    applyStimulus(2'b01, 2'b00, 2'b00, {32'h0, 32'h55});
    checkOutput("irq_t1", 64'(irq), 64'h0);
    @(posedge pclk); #1;
    checkOutput("irq_t2", 64'(irq), 64'h1);
    apb_write(24'h000, 32'h1, e);
    checkOutput("int_clr_pulse", 64'(rf_int_clr), 64'h1);
    checkOutput("irq_lag", 64'(irq), 64'h1);
    @(posedge pclk); #1;
    checkOutput("int_clr_end", 64'(rf_int_clr), 64'h0);
    checkOutput("irq_dropped", 64'(irq), 64'h0);

    // W1C and a new event on the same bit in one cycle.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 24'h000; pwdata = 32'h1;
    @(posedge pclk); #1;
    penable = 1'b1; ir_int = 2'b01; ir_data = {32'h0, 32'hCC};
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; ir_int = '0;
    check_read("set_wins", 24'h000, 32'h1);
    checkOutput("set_wins_irq", 64'(irq), 64'h1);

    // Reset while a frame is still pending.
    applyStimulus(2'b10, 2'b00, 2'b00, {32'hDD, 32'h0});
    prst = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    check_read("mid_rst_fifo", 24'h008, 32'h100);
    check_read("mid_rst_stat", 24'h000, 32'h0);
    check_read("mid_rst_mask", 24'h004, 32'h0);
    check_read("mid_rst_ctrl", 24'h120, 32'h1);
    checkOutput("mid_rst_irq", 64'(irq), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
